// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared types and constants for the pipelined add/subtract unit
// Contents:
//   op_e      : operation select, OP_ADD (A+B) or OP_SUB (A-B)
//   SAT_*     : result mode codes used by the SAT_MODE parameter
package adder_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  localparam int SAT_WRAP = 0;
  localparam int SAT_UNS  = 1;
  localparam int SAT_SGN  = 2;

endpackage

// File: rtl/adder_pipe_stage.sv
// rtl/adder_pipe_stage.sv - one elastic register slice of the add/subtract pipeline
// Ports:
//   clk, rst                      : clock, asynchronous active-low reset
//   src_valid/sum/cout/ovf        : beat offered by the previous slice (or front end)
//   ready                         : this slice can load this cycle
//   next_ready                    : the next slice (or downstream) can load
//   valid/sum/cout/ovf            : beat held by this slice
module adder_pipe_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             src_valid,
  input  logic [WIDTH-1:0] src_sum,
  input  logic             src_cout,
  input  logic             src_ovf,
  output logic             ready,
  input  logic             next_ready,
  output logic             valid,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  // An empty slice always loads, so bubbles collapse toward the output.
  assign ready = !valid || next_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else if (ready) begin
      valid <= src_valid;
      // Payload only moves with a real beat so a drained slice keeps its last value.
      if (src_valid) begin
        sum  <= src_sum;
        cout <= src_cout;
        ovf  <= src_ovf;
      end
    end
  end

endmodule

// File: rtl/adder_pipe.sv
// rtl/adder_pipe.sv - pipelined add/subtract unit with valid/ready handshake and saturation modes
// Ports:
//   clk, rst                : clock, asynchronous active-low reset
//   in_valid/in_ready       : operand handshake
//   in_a, in_b, in_op       : operands and operation (OP_ADD / OP_SUB)
//   out_valid/out_ready     : result handshake
//   out_sum                 : result after the SAT_MODE treatment
//   out_cout                : carry (ADD) or borrow (SUB) of the raw operation
//   out_ovf                 : signed overflow of the raw operation
module adder_pipe
  import adder_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int STAGES   = 2,
  parameter int SAT_MODE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  op_e              in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  if (SAT_MODE < SAT_WRAP || SAT_MODE > SAT_SGN || STAGES < 1 || WIDTH < 2) begin : g_bad_params
    $error("adder_pipe: illegal parameters WIDTH=%0d STAGES=%0d SAT_MODE=%0d",
           WIDTH, STAGES, SAT_MODE);
  end

  // Front end: raw operation at WIDTH+1 bits, flags, then saturation.
  logic [WIDTH:0]   raw;
  logic             raw_cout;
  logic             raw_ovf;
  logic [WIDTH-1:0] res;

  always_comb begin
    raw      = '0;
    raw_ovf  = 1'b0;
    res      = '0;
    if (in_op == OP_SUB) begin
      raw     = {1'b0, in_a} - {1'b0, in_b};
      // Operands of opposite sign and the result sign differs from A.
      raw_ovf = (in_a[WIDTH-1] != in_b[WIDTH-1]) && (raw[WIDTH-1] != in_a[WIDTH-1]);
    end else begin
      raw     = {1'b0, in_a} + {1'b0, in_b};
      // Operands of equal sign and the result sign differs from them.
      raw_ovf = (in_a[WIDTH-1] == in_b[WIDTH-1]) && (raw[WIDTH-1] != in_a[WIDTH-1]);
    end
    res = raw[WIDTH-1:0];
    if (SAT_MODE == SAT_UNS && raw[WIDTH]) begin
      res = (in_op == OP_ADD) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
    end else if (SAT_MODE == SAT_SGN && raw_ovf) begin
      // Overflow direction follows the sign of A for both ADD and SUB.
      res = in_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

  assign raw_cout = raw[WIDTH];

  // Slice 0 is the front end; slices 1..STAGES are registers.
  logic [STAGES:0]   v;
  logic [WIDTH-1:0]  s [0:STAGES];
  logic [STAGES:0]   c;
  logic [STAGES:0]   o;
  logic [STAGES+1:1] r;

  assign v[0]        = in_valid;
  assign s[0]        = res;
  assign c[0]        = raw_cout;
  assign o[0]        = raw_ovf;
  assign r[STAGES+1] = out_ready;

  for (genvar i = 1; i <= STAGES; i++) begin : g_stage
    adder_pipe_stage #(
      .WIDTH(WIDTH)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .src_valid (v[i-1]),
      .src_sum   (s[i-1]),
      .src_cout  (c[i-1]),
      .src_ovf   (o[i-1]),
      .ready     (r[i]),
      .next_ready(r[i+1]),
      .valid     (v[i]),
      .sum       (s[i]),
      .cout      (c[i]),
      .ovf       (o[i])
    );
  end

  assign in_ready  = r[1];
  assign out_valid = v[STAGES];
  assign out_sum   = s[STAGES];
  assign out_cout  = c[STAGES];
  assign out_ovf   = o[STAGES];

endmodule

// File: tb/tb_adder_pipe.sv
// tb/tb_adder_pipe.sv - scoreboard bench for adder_pipe in all three result modes
module tb_adder_pipe;
  import adder_pkg::*;

  localparam int WIDTH  = 8;
  localparam int STAGES = 2;

  typedef struct {
    logic [7:0] s [3];
    logic       cout;
    logic       ovf;
    int         acc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_a;
  logic [7:0] in_b;
  op_e        in_op;
  logic       out_ready;

  logic       ir [3];
  logic       ov [3];
  logic [7:0] os [3];
  logic       oc [3];
  logic       oo [3];

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  bit   lat_chk = 1'b0;

  always #5 clk = ~clk;

  for (genvar m = 0; m < 3; m++) begin : g_dut
    adder_pipe #(
      .WIDTH   (WIDTH),
      .STAGES  (STAGES),
      .SAT_MODE(m)
    ) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (ir[m]),
      .in_a     (in_a),
      .in_b     (in_b),
      .in_op    (in_op),
      .out_valid(ov[m]),
      .out_ready(out_ready),
      .out_sum  (os[m]),
      .out_cout (oc[m]),
      .out_ovf  (oo[m])
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input op_e op,
                                 input int acc);
    exp_t e;
    int ua, ub, sa, sb, ur, sr;
    logic [7:0] wrap;
    ua = int'(a);
    ub = int'(b);
    sa = (ua > 127) ? ua - 256 : ua;
    sb = (ub > 127) ? ub - 256 : ub;
    if (op == OP_ADD) begin
      ur     = ua + ub;
      sr     = sa + sb;
      e.cout = (ur > 255);
    end else begin
      ur     = ua - ub;
      sr     = sa - sb;
      e.cout = (ua < ub);
    end
    wrap   = ur[7:0];
    e.ovf  = (sr > 127) || (sr < -128);
    e.s[0] = wrap;
    e.s[1] = e.cout ? ((op == OP_ADD) ? 8'hFF : 8'h00) : wrap;
    e.s[2] = e.ovf ? ((sr > 127) ? 8'h7F : 8'h80) : wrap;
    e.acc  = acc;
    return e;
  endfunction

  // One clock cycle: drive, settle, score against the model, advance to the next edge.
  task automatic cycle(input logic iv, input logic [7:0] a, input logic [7:0] b,
                       input op_e op, input logic ordy, output bit acc);
    exp_t e;
    in_valid  = iv;
    in_a      = a;
    in_b      = b;
    in_op     = op;
    out_ready = ordy;
    acc       = 1'b0;
    #1;
    check("in_ready", 32'(ir[0]), 32'((q.size() < STAGES) || ordy));
    if (ov[0]) begin
      if (q.size() == 0) begin
        check("leak", 32'(ov[0]), 32'd0);
      end else begin
        e = q[0];
        for (int m = 0; m < 3; m++) begin
          check($sformatf("sum_m%0d", m), 32'(os[m]), 32'(e.s[m]));
        end
        check("cout", 32'(oc[0]), 32'(e.cout));
        check("ovf", 32'(oo[0]), 32'(e.ovf));
        if (ordy) begin
          if (lat_chk) check("latency", 32'(cyc - e.acc), 32'(STAGES));
          void'(q.pop_front());
        end
      end
    end
    if (iv && ir[0]) begin
      q.push_back(model(a, b, op, cyc));
      acc = 1'b1;
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic drain();
    bit acc;
    int n = 0;
    while (q.size() != 0 && n < 50) begin
      cycle(1'b0, 8'h00, 8'h00, OP_ADD, 1'b1, acc);
      n++;
    end
    check("drain_empty", 32'(q.size()), 32'd0);
  endtask

  logic [7:0] va [10] = '{8'h05, 8'hFF, 8'h7F, 8'h00, 8'hF0, 8'h10, 8'h7F, 8'h80, 8'h3C, 8'hA5};
  logic [7:0] vb [10] = '{8'h03, 8'h01, 8'h01, 8'h01, 8'h20, 8'h20, 8'h01, 8'h01, 8'hC4, 8'h5A};
  op_e        vo [10] = '{OP_ADD, OP_ADD, OP_ADD, OP_SUB, OP_ADD, OP_SUB, OP_ADD, OP_SUB,
                          OP_SUB, OP_ADD};

  initial begin
    bit acc;
    int sent, stall_acc, k;

    // Reset held with a beat offered: nothing enters, everything reads zero.
    rst       = 1'b0;
    in_valid  = 1'b1;
    in_a      = 8'h12;
    in_b      = 8'h34;
    in_op     = OP_ADD;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int m = 0; m < 3; m++) begin
      check($sformatf("rst_valid_m%0d", m), 32'(ov[m]), 32'd0);
      check($sformatf("rst_sum_m%0d", m), 32'(os[m]), 32'd0);
      check($sformatf("rst_cout_m%0d", m), 32'(oc[m]), 32'd0);
      check($sformatf("rst_ovf_m%0d", m), 32'(oo[m]), 32'd0);
    end
    in_valid = 1'b0;
    rst      = 1'b1;
    repeat (4) cycle(1'b0, 8'h00, 8'h00, OP_ADD, 1'b1, acc);

    // Single beat, no stall: latency equals STAGES.
    lat_chk = 1'b1;
    cycle(1'b1, 8'h05, 8'h03, OP_ADD, 1'b1, acc);
    check("lat_accept", 32'(acc), 32'd1);
    drain();

    // Directed wrap/flag/saturation vectors, back to back.
    for (int i = 0; i < 10; i++) cycle(1'b1, va[i], vb[i], vo[i], 1'b1, acc);
    drain();
    lat_chk = 1'b0;

    // Backpressure: 6 beats offered while the output is blocked for 5 cycles.
    sent      = 0;
    stall_acc = 0;
    k         = 0;
    while (sent < 6 && k < 100) begin
      cycle(1'b1, va[sent + 2], vb[sent + 2], vo[sent + 2], (k >= 5), acc);
      if (acc) begin
        sent++;
        if (k < 5) stall_acc++;
      end
      k++;
    end
    check("bp_sent", 32'(sent), 32'd6);
    check("bp_stall_accepts", 32'(stall_acc), 32'(STAGES));
    drain();

    // Random traffic with random backpressure.
    for (int i = 0; i < 60; i++) begin
      cycle(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
            op_e'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), acc);
    end
    drain();

    // Reset with two beats in flight: outputs clear at once, flight is discarded.
    cycle(1'b1, 8'h21, 8'h01, OP_ADD, 1'b0, acc);
    cycle(1'b1, 8'h22, 8'h02, OP_SUB, 1'b0, acc);
    check("mid_inflight", 32'(q.size()), 32'd2);
    #1;
    rst = 1'b0;
    #1;
    check("mid_rst_valid", 32'(ov[0]), 32'd0);
    check("mid_rst_sum", 32'(os[0]), 32'd0);
    q.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
    cycle(1'b1, 8'h11, 8'h22, OP_ADD, 1'b1, acc);
    check("post_rst_accept", 32'(acc), 32'd1);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
